// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory bus unit.
// Holds access-size codes, error codes, the controller state encoding and
// the alignment rule used by the controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ACCESS,
    FINISH
  } state_e;

  // Reserved size is treated as a misalignment so it never reaches memory.
  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_unit_if.sv
// mem_bus_unit_if: external memory port (MFA/MFC handshake).
//   master : the bus unit (drives MFA, READ_WRITE, MEMADD, MEMBE, MEMDAT_OUT)
//   slave  : the memory   (drives MEMDAT_IN, MFC)
interface mem_bus_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic                  MFA;
  logic                  READ_WRITE;
  logic [ADDR_W-1:0]     MEMADD;
  logic [DATA_W/8-1:0]   MEMBE;
  logic [DATA_W-1:0]     MEMDAT_OUT;
  logic [DATA_W-1:0]     MEMDAT_IN;
  logic                  MFC;

  modport master (
    output MFA, READ_WRITE, MEMADD, MEMBE, MEMDAT_OUT,
    input  MEMDAT_IN, MFC
  );

  modport slave (
    input  MFA, READ_WRITE, MEMADD, MEMBE, MEMDAT_OUT,
    output MEMDAT_IN, MFC
  );
endinterface

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: combinational byte-lane steering.
//   size/sext/lane : latched access attributes (lane = byte offset in bus word)
//   wdata          : right-justified store data
//   mem_rdata      : raw bus word from memory
//   be             : byte enables for the access
//   wdata_rep      : store data replicated across all lanes
//   rdata_ext      : selected load bytes, right-justified and extended
module mem_lane_steer
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = $clog2(DATA_W / 8)
) (
  input  size_e               size,
  input  logic                sext,
  input  logic [LANE_W-1:0]   lane,
  input  logic [31:0]         wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata_rep,
  output logic [31:0]         rdata_ext
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    case (size)
      SZ_BYTE: be = LANES'(4'h1) << lane;
      SZ_HALF: be = LANES'(4'h3) << lane;
      SZ_WORD: be = LANES'(4'hF) << lane;
      default: be = '0;
    endcase
    // Lane i carries byte (i mod access-bytes) of the store data.
    for (int unsigned i = 0; i < LANES; i++) begin
      case (size)
        SZ_BYTE: wdata_rep[8*i +: 8] = wdata[7:0];
        SZ_HALF: wdata_rep[8*i +: 8] = wdata[8*(i%2) +: 8];
        SZ_WORD: wdata_rep[8*i +: 8] = wdata[8*(i%4) +: 8];
        default: wdata_rep[8*i +: 8] = '0;
      endcase
    end
  end

  always_comb begin
    shifted = 32'(mem_rdata >> {lane, 3'b000});
    case (size)
      SZ_BYTE: rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: single outstanding load/store engine toward external memory.
//   Clk, Reset         : clock, async active-high reset
//   req/wr/size/sext   : request and attributes, sampled in IDLE only
//   addr/wdata         : byte address and right-justified store data
//   busy/done/err      : status; done and err are one-cycle pulses
//   rdata              : extended load result, held until the next load
//   mem                : MFA/MFC memory port (master side)
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [31:0]       rdata,
  mem_bus_unit_if.master    mem
);

  localparam int unsigned LANE_W = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  state_e              state, state_nx;
  logic                wr_q, sext_q;
  size_e               size_q;
  logic [ADDR_W-1:0]   mar;
  logic [31:0]         mbr;
  logic [CNT_W-1:0]    cnt;
  err_e                err_q;
  logic [31:0]         rdata_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   memadd_q;
  logic [DATA_W/8-1:0] membe_q;
  logic [DATA_W-1:0]   memdat_q;
  logic                bad_align, timeout_hit;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   wdata_rep;
  logic [31:0]         rdata_ext;

  mem_lane_steer #(.DATA_W(DATA_W)) u_steer (
    .size      (size_q),
    .sext      (sext_q),
    .lane      (mar[LANE_W-1:0]),
    .wdata     (mbr),
    .mem_rdata (mem.MEMDAT_IN),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign bad_align   = misaligned(size_q, mar[1:0]);
  // Last waiting cycle: the counter would reach TIMEOUT on this edge.
  assign timeout_hit = !mem.MFC && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = CHECK;
      CHECK:   state_nx = bad_align ? IDLE : ACCESS;
      ACCESS:  if (mem.MFC) state_nx = FINISH;
               else if (timeout_hit) state_nx = IDLE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FINISH);
    mem.MFA = (state == ACCESS);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q     <= 1'b0;
      sext_q   <= 1'b0;
      size_q   <= SZ_BYTE;
      mar      <= '0;
      mbr      <= '0;
      cnt      <= '0;
      err_q    <= ERR_NONE;
      rdata_q  <= '0;
      rw_q     <= 1'b1;
      memadd_q <= '0;
      membe_q  <= '0;
      memdat_q <= '0;
    end else begin
      err_q <= ERR_NONE;
      case (state)
        IDLE: if (req) begin
          wr_q   <= wr;
          sext_q <= sext;
          size_q <= size_e'(size);
          mar    <= addr;
          mbr    <= wdata;
        end
        CHECK: if (bad_align) begin
          err_q <= ERR_ALIGN;
        end else begin
          memadd_q <= {mar[ADDR_W-1:LANE_W], LANE_W'(0)};
          membe_q  <= be;
          memdat_q <= wdata_rep;
          rw_q     <= ~wr_q;
          cnt      <= '0;
        end
        ACCESS: if (mem.MFC) begin
          if (!wr_q) rdata_q <= rdata_ext;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (timeout_hit) err_q <= ERR_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem.READ_WRITE = rw_q;
  assign mem.MEMADD     = memadd_q;
  assign mem.MEMBE      = membe_q;
  assign mem.MEMDAT_OUT = memdat_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: drives a 32-bit and a 64-bit mem_bus_unit with identical
// requests and MFC timing; each has its own memory read data.
module tb_mem_bus_unit;

  localparam int unsigned TO = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req, wr, sext;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        mfc;
  logic [31:0] md32;
  logic [63:0] md64;

  logic        busy32, done32, busy64, done64;
  logic [1:0]  err32, err64;
  logic [31:0] rdata32, rdata64;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd32, exp_rd64;
  bit prev_finish;

  mem_bus_unit_if #(.ADDR_W(8), .DATA_W(32)) bus32 ();
  mem_bus_unit_if #(.ADDR_W(8), .DATA_W(64)) bus64 ();

  assign bus32.MFC       = mfc;
  assign bus64.MFC       = mfc;
  assign bus32.MEMDAT_IN = md32;
  assign bus64.MEMDAT_IN = md64;

  mem_bus_unit #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(TO)) u32 (
    .Clk(Clk), .Reset(Reset), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy32), .done(done32), .err(err32),
    .rdata(rdata32), .mem(bus32)
  );

  mem_bus_unit #(.DATA_W(64), .ADDR_W(8), .TIMEOUT(TO)) u64 (
    .Clk(Clk), .Reset(Reset), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy64), .done(done64), .err(err64),
    .rdata(rdata64), .mem(bus64)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules: nb = bus bytes, access bytes = 2**sz, lane = addr mod nb.
  function automatic logic [63:0] m_be(input int nb, input int sz, input int a);
    return ((64'd1 << (1 << sz)) - 64'd1) << (a % nb);
  endfunction

  function automatic logic [63:0] m_addr(input int nb, input int a);
    return 64'(a - (a % nb));
  endfunction

  function automatic logic [63:0] m_dout(input int nb, input int sz, input logic [31:0] wd);
    logic [63:0] r = '0;
    int n = 1 << sz;
    for (int j = 0; j < nb; j++)
      r = r | (64'((wd >> (8 * (j % n))) & 32'hFF) << (8 * j));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input int nb, input int sz, input bit sx,
                                         input int a, input logic [63:0] m);
    int n = 1 << sz;
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v = (m >> (8 * (a % nb))) & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bit m_bad(input int sz, input int a);
    return (sz == 3) || ((a % (1 << sz)) != 0);
  endfunction

  // Issue one request and check every cycle until its done/err cycle.
  // d = ACCESS cycle (1-based) in which MFC is high; outside 1..TO means never.
  task automatic xact(input bit w, input int sz, input bit sx, input int a,
                      input logic [31:0] wd, input int d,
                      input logic [31:0] mem32, input logic [63:0] mem64);
    bit bad = m_bad(sz, a);
    bit ok  = !bad && d >= 1 && d <= int'(TO);
    int acc = ok ? d : int'(TO);
    int last = bad ? 2 : acc + 2;
    bit e_acc, e_done, e_busy;
    logic [1:0] e_err;
    req = 1'b1; wr = w; size = sz[1:0]; sext = sx; addr = a[7:0]; wdata = wd;
    if (prev_finish) begin
      // Request raised during the done cycle is taken one cycle later.
      @(posedge Clk); #1;
      mfc = 1'($urandom);
      @(negedge Clk);
      chk("b2b_busy32", 64'(busy32), 64'd0);
      chk("b2b_busy64", 64'(busy64), 64'd0);
      chk("b2b_done32", 64'(done32), 64'd0);
    end
    for (int c = 1; c <= last; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
        addr = 8'($urandom); wdata = $urandom;
      end
      if (!bad && c >= 2 && c <= acc + 1) mfc = (c - 1 == d);
      else mfc = 1'($urandom);
      md32 = $urandom; md64 = {$urandom, $urandom};
      if (!bad && c - 1 == d) begin md32 = mem32; md64 = mem64; end
      @(negedge Clk);
      e_acc  = !bad && c >= 2 && c <= acc + 1;
      e_done = ok && c == last;
      e_busy = (c < last) || e_done;
      e_err  = (c != last) ? 2'd0 : bad ? 2'd1 : ok ? 2'd0 : 2'd2;
      if (e_done && !w) begin
        exp_rd32 = m_load(4, sz, sx, a, 64'(mem32));
        exp_rd64 = m_load(8, sz, sx, a, mem64);
      end
      chk("busy32", 64'(busy32), 64'(e_busy));
      chk("busy64", 64'(busy64), 64'(e_busy));
      chk("done32", 64'(done32), 64'(e_done));
      chk("done64", 64'(done64), 64'(e_done));
      chk("err32", 64'(err32), 64'(e_err));
      chk("err64", 64'(err64), 64'(e_err));
      chk("mfa32", 64'(bus32.MFA), 64'(e_acc));
      chk("mfa64", 64'(bus64.MFA), 64'(e_acc));
      chk("rdata32", 64'(rdata32), 64'(exp_rd32));
      chk("rdata64", 64'(rdata64), 64'(exp_rd64));
      if (e_acc) begin
        chk("addr32", 64'(bus32.MEMADD), m_addr(4, a));
        chk("addr64", 64'(bus64.MEMADD), m_addr(8, a));
        chk("be32", 64'(bus32.MEMBE), m_be(4, sz, a));
        chk("be64", 64'(bus64.MEMBE), m_be(8, sz, a));
        chk("dout32", 64'(bus32.MEMDAT_OUT), m_dout(4, sz, wd));
        chk("dout64", 64'(bus64.MEMDAT_OUT), m_dout(8, sz, wd));
        chk("rw32", 64'(bus32.READ_WRITE), 64'(!w));
        chk("rw64", 64'(bus64.READ_WRITE), 64'(!w));
      end
    end
    prev_finish = ok;
  endtask

  initial begin
    Reset = 1'b1; req = 1'b0; wr = 1'b0; size = '0; sext = 1'b0;
    addr = '0; wdata = '0; mfc = 1'b0; md32 = '0; md64 = '0;
    exp_rd32 = '0; exp_rd64 = '0; prev_finish = 1'b0;
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done64", 64'(done64), 64'd0);
    chk("rst_err32", 64'(err32), 64'd0);
    chk("rst_rdata64", 64'(rdata64), 64'd0);
    chk("rst_mfa32", 64'(bus32.MFA), 64'd0);
    chk("rst_rw64", 64'(bus64.READ_WRITE), 64'd1);
    chk("rst_addr32", 64'(bus32.MEMADD), 64'd0);
    chk("rst_be64", 64'(bus64.MEMBE), 64'd0);
    chk("rst_dout64", 64'(bus64.MEMDAT_OUT), 64'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;

    // Signed byte load from the top lane, MFC on the second ACCESS cycle.
    xact(1'b0, 0, 1'b1, 'h03, 32'h0, 2, 32'h80112233, 64'h0000_0000_8011_2233);
    chk("tp_ldb_rdata32", 64'(rdata32), 64'hFFFF_FF80);
    chk("tp_ldb_be32", 64'(bus32.MEMBE), 64'h8);

    // Halfword store to lanes 2..3; load result must stay untouched.
    xact(1'b1, 1, 1'b0, 'h06, 32'h0000ABCD, 1, $urandom, 64'h0);
    chk("tp_sth_dout32", 64'(bus32.MEMDAT_OUT), 64'hABCD_ABCD);
    chk("tp_sth_be32", 64'(bus32.MEMBE), 64'hC);
    chk("tp_sth_addr32", 64'(bus32.MEMADD), 64'h04);
    chk("tp_sth_rw32", 64'(bus32.READ_WRITE), 64'd0);
    chk("tp_sth_rdata32", 64'(rdata32), 64'hFFFF_FF80);

    // Misaligned word and reserved size.
    xact(1'b0, 2, 1'b0, 'h05, 32'h0, 1, 32'h0, 64'h0);
    xact(1'b0, 3, 1'b0, 'h00, 32'h0, 1, 32'h0, 64'h0);

    // Timeout with MFC never arriving.
    xact(1'b0, 2, 1'b0, 'h08, 32'h0, 0, 32'h0, 64'h0);

    // Asynchronous reset in the middle of an access.
    req = 1'b1; wr = 1'b0; size = 2'd2; sext = 1'b0; addr = 8'h20; wdata = '0; mfc = 1'b0;
    @(posedge Clk); #1; req = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("mid_mfa32", 64'(bus32.MFA), 64'd1);
    #2 Reset = 1'b1;
    #1;
    exp_rd32 = '0; exp_rd64 = '0;
    chk("arst_mfa32", 64'(bus32.MFA), 64'd0);
    chk("arst_mfa64", 64'(bus64.MFA), 64'd0);
    chk("arst_busy32", 64'(busy32), 64'd0);
    chk("arst_busy64", 64'(busy64), 64'd0);
    chk("arst_done32", 64'(done32), 64'd0);
    chk("arst_err32", 64'(err32), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    prev_finish = 1'b0;

    // MFC on exactly the last allowed ACCESS cycle completes normally.
    xact(1'b0, 2, 1'b0, 'h08, 32'h0, int'(TO), 32'h1234_5678, 64'h0000_0000_1234_5678);

    // Zero-extended halfword from the top of a 64-bit bus.
    xact(1'b0, 1, 1'b0, 'h0E, 32'h0, 1, 32'hBEEF_0000, 64'hBEEF_0000_0000_0000);
    chk("tp_ldh_rdata64", 64'(rdata64), 64'h0000_BEEF);
    chk("tp_ldh_be64", 64'(bus64.MEMBE), 64'hC0);
    chk("tp_ldh_addr64", 64'(bus64.MEMADD), 64'h08);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      int a  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a = a - (a % (1 << (sz % 3)));
      xact(1'($urandom), sz, 1'($urandom), a, $urandom,
           int'($urandom_range(0, int'(TO) + 2)), $urandom, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_unit.md
Name: mem_bus_unit

Overview:
Parametrised successor to the single MAR/MBR pair and bare MFA/MFC wiring of the current CPU top. It accepts one load or store request from the control unit and drives the MFA/MFC handshake to memory. It supports byte, halfword and word sizes with byte enables, lane steering, sign/zero extension, alignment checking and a timeout. It sits between the control unit/datapath and the external memory port.

Parameters:
DATA_W, 32, memory data bus width in bits; power of two, at least 32.
ADDR_W, 8, byte address width.
TIMEOUT, 15, maximum cycles spent waiting for MFC before abort; at least 1.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
req  in  1  access request from the control unit; sampled in IDLE only.
wr  in  1  1 = store, 0 = load.
size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  in  ADDR_W  byte address.
wdata  in  32  store data, right-justified.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  2  one-cycle code: 0 = none, 1 = misaligned/reserved size, 2 = timeout.
rdata  out  32  extended load result; holds until the next load completes.
MFA  out  1  memory function active.
READ_WRITE  out  1  1 = read, 0 = write.
MEMADD  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero).
MEMBE  out  DATA_W/8  byte enables.
MEMDAT_OUT  out  DATA_W  store data, replicated across lanes.
MEMDAT_IN  in  DATA_W  load data from memory.
MFC  in  1  memory function complete.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, err=0, rdata=0, MFA=0, READ_WRITE=1, MEMADD=0, MEMBE=0, MEMDAT_OUT=0, timeout counter=0. A reset mid-access aborts it with no done and no err pulse.
- FSM states: IDLE, CHECK, ACCESS, FINISH.
- IDLE:
  - req=1 latches wr, size, sext, addr and wdata into internal MAR/MBR.
  - Go to CHECK.
  - req is ignored while busy; no queueing.
- CHECK (1 cycle): misaligned if any of:
  - size=1 and addr[0]=1
  - size=2 and addr[1:0]!=0
  - size=3
  - Misaligned: err=1 for one cycle, MFA never asserted, return to IDLE.
  - Otherwise: drive MEMADD, MEMBE, READ_WRITE=~wr and MEMDAT_OUT; clear the counter; go to ACCESS.
- ACCESS:
  - MFA=1 with all memory outputs stable.
  - Counter increments each cycle that MFC=0.
  - MFC=1: capture MEMDAT_IN on load, go to FINISH.
  - Counter reaching TIMEOUT with MFC=0: MFA drops, err=2 pulse, go to IDLE.
  - MFC=1 and timeout in the same cycle: MFC wins.
- FINISH: MFA=0; done=1 for one cycle; rdata updated on the same edge for loads; return to IDLE. Stores leave rdata unchanged.
- Latency:
  - Misaligned request: err 2 cycles after the req edge.
  - MFC already high on the first ACCESS cycle: done 3 cycles after the req edge.
  - Back-to-back: req may be asserted in the cycle done is high; it is accepted next cycle in IDLE.
- Lane rules (L = addr mod DATA_W/8):
  - Byte: MEMBE = 1<<L.
  - Half: MEMBE = 3<<L.
  - Word: MEMBE = 0xF<<L.
  - MEMDAT_OUT = wdata low 8/16/32 bits replicated to fill DATA_W.
  - Load: selected bytes shifted right by 8*L, then zero- or sign-extended to 32 bits.
- MFC outside ACCESS is ignored. MEMDAT_IN is sampled only on the ACCESS->FINISH edge.

Decomposition:
- Package mem_bus_pkg holds:
  - size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_RSVD=3
  - err codes ERR_NONE=0, ERR_ALIGN=1, ERR_TIMEOUT=2
  - state encoding.
- One combinational sub-module, mem_lane_steer, handles MEMBE and MEMDAT_OUT generation plus load extraction and extension. The FSM, counter and MAR/MBR registers stay in mem_bus_unit.

Test Plan:
- Load byte, DATA_W=32, addr=0x03, sext=1, MEMDAT_IN=0x80112233, MFC high on the 2nd ACCESS cycle -> MEMBE=0x8, MEMADD=0x00, rdata=0xFFFFFF80, done 4 cycles after req, err=0.
- Store half, addr=0x06, wdata=0x0000ABCD -> MEMADD=0x04, MEMBE=0xC, MEMDAT_OUT=0xABCDABCD, READ_WRITE=0, done pulse, rdata unchanged.
- Load word, addr=0x05 -> err=1 two cycles after req, MFA never high, busy back to 0 after 2 cycles. Separately size=3, addr=0 -> err=1.
- Load word, addr=0x08, TIMEOUT=15, MFC held 0 -> MFA high for exactly 15 cycles, then err=2, no done. Then MFC=1 on exactly the 15th cycle -> done, no err.
- Reset asserted asynchronously mid-ACCESS with MFA=1 -> MFA=0 and busy=0 immediately with no done/err. A new req after reset completes normally.
- DATA_W=64, load half, addr=0x0E, sext=0, MEMDAT_IN=0xBEEF000000000000 -> MEMBE=0xC0, MEMADD=0x08, rdata=0x0000BEEF.
